// File: rtl/draw_controller_pkg.sv
// ============================================================================
//  Module   : draw_pkg
//  Purpose  : Shared state encoding, frame geometry defaults and colour codes
//             for the draw controller and its datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_pkg;

  // State register encoding, kept as plain 4-bit constants so legacy
  // datapath/debug logic can decode the raw value.
  typedef logic [3:0] state_t;

  localparam state_t S_IDLE       = 4'd0;
  localparam state_t S_BLACK      = 4'd1;
  localparam state_t S_D_BLACK    = 4'd2;
  localparam state_t S_LEFT       = 4'd3;
  localparam state_t S_D_LEFT     = 4'd4;
  localparam state_t S_RIGHT      = 4'd5;
  localparam state_t S_D_RIGHT    = 4'd6;
  localparam state_t S_CAR        = 4'd7;
  localparam state_t S_D_CAR      = 4'd8;
  localparam state_t S_WAIT_FRAME = 4'd9;
  localparam state_t S_ERASE      = 4'd10;
  localparam state_t S_D_ERASE    = 4'd11;
  localparam state_t S_UPDATE     = 4'd12;

  // Frame geometry defaults
  localparam int c_SCREEN_W = 160;
  localparam int c_SCREEN_H = 120;
  localparam int c_GRASS_W  = 20;

  // Colour codes shared with the datapath
  localparam logic [2:0] c_BLACK = 3'b000;
  localparam logic [2:0] c_GREEN = 3'b010;
  localparam logic [2:0] c_RED   = 3'b100;

  // Last counter value of a dimension, truncated to the 8-bit counter width
  // (a dimension of 256 maps to 255).
  function automatic logic [7:0] dim_m1(input int unsigned dim);
    return 8'(dim - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/draw_controller_if.sv
// ============================================================================
//  Module   : draw_if
//  Purpose  : Controller <-> datapath bus: mode selects and counter strobes
//             one way, column/row counters back.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface draw_if;

  logic [7:0] counterx;
  logic [7:0] countery;
  logic       draw_bg_black;
  logic       draw_bg_green_left;
  logic       draw_bg_green_right;
  logic       draw_car;
  logic       erase;
  logic       update;
  logic       plot;
  logic       inc;
  logic       done;

  modport master (
    input  counterx, countery,
    output draw_bg_black, draw_bg_green_left, draw_bg_green_right,
           draw_car, erase, update, plot, inc, done
  );

  modport slave (
    output counterx, countery,
    input  draw_bg_black, draw_bg_green_left, draw_bg_green_right,
           draw_car, erase, update, plot, inc, done
  );

endinterface

`default_nettype wire

// File: rtl/draw_controller_region_scan.sv
// ============================================================================
//  Module   : region_scan
//  Purpose  : Row-wrap and last-pixel detection for a W x H region scanned by
//             the datapath counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module region_scan (
  input  logic       en,
  input  logic [7:0] w_m1,
  input  logic [7:0] h_m1,
  input  logic [7:0] counterx,
  input  logic [7:0] countery,
  output logic       inc,
  output logic       last
);

  // Row wraps on the last column; the region ends on the last column of the
  // last row.
  assign inc  = en & (counterx == w_m1);
  assign last = inc & (countery == h_m1);

endmodule

`default_nettype wire

// File: rtl/draw_controller.sv
// ============================================================================
//  Module   : draw_controller
//  Purpose  : Moore FSM sequencing background, grass strips, car draw, erase
//             and position update for the 160x120 frame.
//  Options  : DRAW_CTRL_PAUSE_EN - adds a 'pause' input that holds the FSM in
//             S_WAIT_FRAME while high.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_controller
  import draw_pkg::*;
#(
  parameter int SCREEN_W = c_SCREEN_W,
  parameter int SCREEN_H = c_SCREEN_H,
  parameter int GRASS_W  = c_GRASS_W,
  parameter int CAR_W    = 8,
  parameter int CAR_H    = 12
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   start,
  input  logic   frame_tick,
`ifdef DRAW_CTRL_PAUSE_EN
  input  logic   pause,
`endif
  output logic   busy,
  draw_if.master dp
);

  localparam logic [7:0] c_SCREEN_W_M1 = dim_m1(SCREEN_W);
  localparam logic [7:0] c_SCREEN_H_M1 = dim_m1(SCREEN_H);
  localparam logic [7:0] c_GRASS_W_M1  = dim_m1(GRASS_W);
  localparam logic [7:0] c_CAR_W_M1    = dim_m1(CAR_W);
  localparam logic [7:0] c_CAR_H_M1    = dim_m1(CAR_H);

  state_t     r_state;
  state_t     w_next;
  logic       r_tick_pending;
  logic       w_pause;
  logic       w_is_draw;
  logic       w_leave_wait;
  logic       w_last;
  logic [7:0] w_w_m1;
  logic [7:0] w_h_m1;

`ifdef DRAW_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_is_draw = (r_state == S_BLACK) | (r_state == S_LEFT) |
                     (r_state == S_RIGHT) | (r_state == S_CAR)  |
                     (r_state == S_ERASE);

  assign w_leave_wait = (r_state == S_WAIT_FRAME) &
                        (frame_tick | r_tick_pending) & ~w_pause;

  // Region dimensions selected by the current draw state
  always_comb begin
    w_w_m1 = 8'd0;
    w_h_m1 = 8'd0;
    case (r_state)
      S_BLACK: begin
        w_w_m1 = c_SCREEN_W_M1;
        w_h_m1 = c_SCREEN_H_M1;
      end
      S_LEFT, S_RIGHT: begin
        w_w_m1 = c_GRASS_W_M1;
        w_h_m1 = c_SCREEN_H_M1;
      end
      S_CAR, S_ERASE: begin
        w_w_m1 = c_CAR_W_M1;
        w_h_m1 = c_CAR_H_M1;
      end
      default: begin
        w_w_m1 = 8'd0;
        w_h_m1 = 8'd0;
      end
    endcase
  end

  region_scan u_scan (
    .en       (w_is_draw),
    .w_m1     (w_w_m1),
    .h_m1     (w_h_m1),
    .counterx (dp.counterx),
    .countery (dp.countery),
    .inc      (dp.inc),
    .last     (w_last)
  );

  // Next-state sequencing; the background is drawn once, after that only
  // erase/update/car rounds follow each frame tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = S_BLACK;
      S_BLACK:      if (w_last) w_next = S_D_BLACK;
      S_D_BLACK:    w_next = S_LEFT;
      S_LEFT:       if (w_last) w_next = S_D_LEFT;
      S_D_LEFT:     w_next = S_RIGHT;
      S_RIGHT:      if (w_last) w_next = S_D_RIGHT;
      S_D_RIGHT:    w_next = S_CAR;
      S_CAR:        if (w_last) w_next = S_D_CAR;
      S_D_CAR:      w_next = S_WAIT_FRAME;
      S_WAIT_FRAME: if (w_leave_wait) w_next = S_ERASE;
      S_ERASE:      if (w_last) w_next = S_D_ERASE;
      S_D_ERASE:    w_next = S_UPDATE;
      S_UPDATE:     w_next = S_CAR;
      default:      w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Remember a tick that arrives while it cannot be served; ticks collapse
  // into one, and the flag is consumed when the wait state is left.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)           r_tick_pending <= 1'b0;
    else if (w_leave_wait) r_tick_pending <= 1'b0;
    else if (frame_tick)   r_tick_pending <= 1'b1;
  end

  assign dp.draw_bg_black       = (r_state == S_BLACK);
  assign dp.draw_bg_green_left  = (r_state == S_LEFT);
  assign dp.draw_bg_green_right = (r_state == S_RIGHT);
  assign dp.draw_car            = (r_state == S_CAR);
  assign dp.erase               = (r_state == S_ERASE);
  assign dp.update              = (r_state == S_UPDATE);
  assign dp.plot                = w_is_draw;
  assign dp.done                = (r_state == S_D_BLACK) | (r_state == S_D_LEFT) |
                                  (r_state == S_D_RIGHT) | (r_state == S_D_CAR)  |
                                  (r_state == S_D_ERASE);
  assign busy                   = (r_state != S_IDLE) & (r_state != S_WAIT_FRAME);

endmodule

`default_nettype wire
